// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: hazard and stall control for a five-stage pipeline.
// Generates PC/latch enables and flushes for load-use bubbles, branch
// redirects and multi-cycle mult/div operations, and counts front-end stall
// cycles in a saturating 16-bit counter.
// Optional feature: define MD_TIMEOUT_EN to abort a mult/div that waits
// more than MD_TIMEOUT cycles for md_ready, setting the sticky md_err flag.
module pipe_stall_ctrl #(
  parameter int unsigned MD_TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  fd_rs1,
  input  logic [4:0]  fd_rs2,
  input  logic        fd_uses_rs2,
  input  logic [4:0]  dx_rd,
  input  logic        dx_is_load,
  input  logic        dx_is_md,
  input  logic        branch_taken,
  input  logic        md_ready,
  output logic        pc_en,
  output logic        fd_en,
  output logic        dx_en,
  output logic        xm_en,
  output logic        mw_en,
  output logic        fd_flush,
  output logic        dx_flush,
  output logic        xm_flush,
  output logic        md_start,
  output logic        md_busy,
  output logic        md_err,
  output logic [15:0] stall_cycles
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state;
  logic   load_use;
  logic   md_release;

  assign load_use = dx_is_load && (dx_rd != 5'd0) &&
                    ((dx_rd == fd_rs1) || (fd_uses_rs2 && (dx_rd == fd_rs2)));

`ifdef MD_TIMEOUT_EN
  localparam int unsigned TW = $clog2(MD_TIMEOUT + 1) + 1;

  logic [TW-1:0] to_cnt;
  logic          to_hit;

  assign to_hit     = (to_cnt >= TW'(MD_TIMEOUT));
  assign md_release = md_ready || to_hit;

  // Timeout counter (zero on BUSY entry, +1 per BUSY cycle) and sticky error
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
      md_err <= 1'b0;
    end else if (state == IDLE) begin
      to_cnt <= '0;
    end else begin
      if (!to_hit) to_cnt <= to_cnt + 1'b1;
      if (to_hit && !md_ready) md_err <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^MD_TIMEOUT;
  assign md_release         = md_ready;
  assign md_err             = 1'b0;
`endif

  // Control decode: reset > mult/div > branch flush > load-use > normal
  always_comb begin
    pc_en    = 1'b0;
    fd_en    = 1'b0;
    dx_en    = 1'b0;
    xm_en    = 1'b0;
    mw_en    = 1'b0;
    fd_flush = 1'b0;
    dx_flush = 1'b0;
    xm_flush = 1'b0;
    md_start = 1'b0;
    md_busy  = 1'b0;
    if (!reset) begin
      mw_en = 1'b1;
      if (state == BUSY) begin
        md_busy = 1'b1;
        xm_en   = 1'b1;
        if (md_release) begin
          pc_en = 1'b1;
          fd_en = 1'b1;
          dx_en = 1'b1;
        end else begin
          xm_flush = 1'b1;
        end
      end else if (dx_is_md) begin
        md_start = 1'b1;
        xm_en    = 1'b1;
        xm_flush = 1'b1;
      end else if (branch_taken) begin
        pc_en    = 1'b1;
        fd_en    = 1'b1;
        dx_en    = 1'b1;
        xm_en    = 1'b1;
        fd_flush = 1'b1;
        dx_flush = 1'b1;
      end else if (load_use) begin
        dx_en    = 1'b1;
        xm_en    = 1'b1;
        dx_flush = 1'b1;
      end else begin
        pc_en = 1'b1;
        fd_en = 1'b1;
        dx_en = 1'b1;
        xm_en = 1'b1;
      end
    end
  end

  // FSM state and saturating stall-cycle counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      stall_cycles <= '0;
    end else begin
      case (state)
        IDLE:    if (dx_is_md) state <= BUSY;
        BUSY:    if (md_release) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (!pc_en && (stall_cycles != '1)) stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule
